// File: rtl/ns_arb_2to1.sv
// Two-input round-robin / fixed-priority merge arbiter for the ns channel fabric.
// Optional redundancy check on buffered messages: define NS_ARB_REDUN_CHECK_EN.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 32
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

module ns_arb_2to1 #(
  parameter int ASZ        = `NS_ADDRESS_SIZE,
  parameter int DSZ        = `NS_DATA_SIZE,
  parameter int RSZ        = `NS_REDUN_SIZE,
  parameter int FIXED_PRIO = 0,
  parameter int CSZ        = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  input  logic [ASZ-1:0] i1_src,
  input  logic [ASZ-1:0] i1_dst,
  input  logic [DSZ-1:0] i1_dat,
  input  logic [RSZ-1:0] i1_red,
  input  logic           i1_req,
  output logic           i1_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic           grant,
  output logic [CSZ-1:0] cnt0,
  output logic [CSZ-1:0] cnt1,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, IN_ACK, OUT_REQ, OUT_REL} state_t;

  state_t         state_q, state_d;
  logic           req0_q, req0_d, req1_q, req1_d;
  logic           ack0_q, ack0_d, ack1_q, ack1_d;
  logic           oreq_q, oreq_d;
  logic           grant_q, grant_d;
  logic           err_q, err_d;
  logic [ASZ-1:0] src_q, src_d, dst_q, dst_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic [RSZ-1:0] red_q, red_d;
  logic [CSZ-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic           elig0, elig1, pick, cur_req;

`ifdef NS_ARB_REDUN_CHECK_EN
  // Every message bit folds into redundancy bit (index mod RSZ) by XOR.
  function automatic logic [RSZ-1:0] calc_redun(input logic [ASZ-1:0] s,
                                                input logic [ASZ-1:0] d,
                                                input logic [DSZ-1:0] t);
    logic [2*ASZ+DSZ-1:0] v;
    v = {s, d, t};
    calc_redun = '0;
    for (int i = 0; i < 2*ASZ+DSZ; i++) calc_redun[i % RSZ] ^= v[i];
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    req0_d  = i0_req;
    req1_d  = i1_req;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    oreq_d  = oreq_q;
    grant_d = grant_q;
    err_d   = err_q;
    src_d   = src_q;
    dst_d   = dst_q;
    dat_d   = dat_q;
    red_d   = red_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    elig0   = req0_q & ~ack0_q;
    elig1   = req1_q & ~ack1_q;
    pick    = grant_q;
    cur_req = grant_q ? i1_req : i0_req;

    case (state_q)
      IDLE: begin
        if (o0_ack) begin
          err_d = 1'b1;
        end else if (elig0 || elig1) begin
          if (elig0 && elig1) pick = (FIXED_PRIO != 0) ? 1'b0 : ~grant_q;
          else                pick = elig1;
          grant_d = pick;
          state_d = IN_ACK;
          if (pick) begin
            src_d  = i1_src;
            dst_d  = i1_dst;
            dat_d  = i1_dat;
            red_d  = i1_red;
            ack1_d = 1'b1;
          end else begin
            src_d  = i0_src;
            dst_d  = i0_dst;
            dat_d  = i0_dat;
            red_d  = i0_red;
            ack0_d = 1'b1;
          end
        end
      end
      IN_ACK: begin
        if (o0_ack) err_d = 1'b1;
        if (!cur_req) begin
          if (grant_q) ack1_d = 1'b0;
          else         ack0_d = 1'b0;
`ifdef NS_ARB_REDUN_CHECK_EN
          // A corrupted message is dropped here; grant has already advanced.
          if (calc_redun(src_q, dst_q, dat_q) != red_q) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            oreq_d  = 1'b1;
            state_d = OUT_REQ;
          end
`else
          oreq_d  = 1'b1;
          state_d = OUT_REQ;
`endif
        end
      end
      OUT_REQ: begin
        if (o0_ack) begin
          oreq_d  = 1'b0;
          state_d = OUT_REL;
          if (grant_q) cnt1_d = cnt1_q + 1'b1;
          else         cnt0_d = cnt0_q + 1'b1;
        end
      end
      OUT_REL: begin
        if (!o0_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req0_q  <= 1'b0;
      req1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      oreq_q  <= 1'b0;
      grant_q <= 1'b1;
      err_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      dat_q   <= '0;
      red_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      req0_q  <= req0_d;
      req1_q  <= req1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      oreq_q  <= oreq_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      dat_q   <= dat_d;
      red_q   <= red_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign i0_ack = ack0_q;
  assign i1_ack = ack1_q;
  assign o0_req = oreq_q;
  assign o0_src = src_q;
  assign o0_dst = dst_q;
  assign o0_dat = dat_q;
  assign o0_red = red_q;
  assign grant  = grant_q;
  assign cnt0   = cnt0_q;
  assign cnt1   = cnt1_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ns_arb_2to1.sv
// Bench for ns_arb_2to1: instance 0 is round-robin with 8-bit counters,
// instance 1 is fixed priority with 2-bit counters; checked against a message-order model.
`timescale 1ns/1ps

module tb_ns_arb_2to1;

  localparam int ASZ = 8;
  localparam int DSZ = 16;
  localparam int RSZ = 4;
  localparam int MW  = 2*ASZ + DSZ + RSZ;
  localparam int TMO = 1000;
`ifdef NS_ARB_REDUN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef logic [MW:0] acc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [ASZ-1:0] i_src [2][2];
  logic [ASZ-1:0] i_dst [2][2];
  logic [DSZ-1:0] i_dat [2][2];
  logic [RSZ-1:0] i_red [2][2];
  logic           i_req [2][2];
  wire            i_ack [2][2];
  wire  [ASZ-1:0] o_src [2];
  wire  [ASZ-1:0] o_dst [2];
  wire  [DSZ-1:0] o_dat [2];
  wire  [RSZ-1:0] o_red [2];
  wire            o_req [2];
  logic           o_ack [2];
  wire            grant [2];
  wire  [7:0]     cnt0 [2];
  wire  [7:0]     cnt1 [2];
  wire            err [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CW = (g == 0) ? 8 : 2;
    wire [CW-1:0] c0, c1;
    ns_arb_2to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .FIXED_PRIO(g), .CSZ(CW)) u_dut (
      .clk(clk), .reset(reset),
      .i0_src(i_src[g][0]), .i0_dst(i_dst[g][0]), .i0_dat(i_dat[g][0]), .i0_red(i_red[g][0]),
      .i0_req(i_req[g][0]), .i0_ack(i_ack[g][0]),
      .i1_src(i_src[g][1]), .i1_dst(i_dst[g][1]), .i1_dat(i_dat[g][1]), .i1_red(i_red[g][1]),
      .i1_req(i_req[g][1]), .i1_ack(i_ack[g][1]),
      .o0_src(o_src[g]), .o0_dst(o_dst[g]), .o0_dat(o_dat[g]), .o0_red(o_red[g]),
      .o0_req(o_req[g]), .o0_ack(o_ack[g]),
      .grant(grant[g]), .cnt0(c0), .cnt1(c1), .err(err[g])
    );
    assign cnt0[g] = 8'(c0);
    assign cnt1[g] = 8'(c1);
  end

  int   nChecks = 0;
  int   nFails  = 0;
  acc_t acc_q [2][$];
  int   order_q [2][$];
  int   cnt_model [2][2];
  int   oreq_rises [2];
  logic prev_oreq [2];

  // Counts o0_req rising edges per instance, independent of the model.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (o_req[g] === 1'b1 && prev_oreq[g] !== 1'b1) oreq_rises[g]++;
      prev_oreq[g] = o_req[g];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RSZ-1:0] calcRedun(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                               input logic [DSZ-1:0] t);
    logic [2*ASZ+DSZ-1:0] v;
    logic [RSZ-1:0] r;
    v = {s, d, t};
    r = '0;
    for (int c = 0; c < (2*ASZ+DSZ)/RSZ; c++) r = r ^ v[c*RSZ +: RSZ];
    return r;
  endfunction

  task automatic applyReset();
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      o_ack[g] = 1'b0;
      for (int k = 0; k < 2; k++) i_req[g][k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      acc_q[g].delete();
      order_q[g].delete();
      cnt_model[g][0] = 0;
      cnt_model[g][1] = 0;
    end
  endtask

  // One 4-phase transfer on input k of instance g; accepted messages enter the forward queue.
  task automatic applyStimulus(input int g, input int k, input logic [ASZ-1:0] s,
                               input logic [ASZ-1:0] d, input logic [DSZ-1:0] t,
                               input logic [RSZ-1:0] r);
    i_src[g][k] = s;
    i_dst[g][k] = d;
    i_dat[g][k] = t;
    i_red[g][k] = r;
    i_req[g][k] = 1'b1;
    for (int n = 0; n < TMO && i_ack[g][k] !== 1'b1; n++) @(negedge clk);
    if (i_ack[g][k] !== 1'b1) begin
      checkOutput("ack_rise_timeout", 64'(i_ack[g][k]), 64'd1);
      i_req[g][k] = 1'b0;
      return;
    end
    if (!CHECK_EN || r == calcRedun(s, d, t)) acc_q[g].push_back({k[0], s, d, t, r});
    i_req[g][k] = 1'b0;
    for (int n = 0; n < TMO && i_ack[g][k] !== 1'b0; n++) @(negedge clk);
    if (i_ack[g][k] !== 1'b0) checkOutput("ack_fall_timeout", 64'(i_ack[g][k]), 64'd0);
  endtask

  task automatic streamMsgs(input int g, input int k, input int n, input int gapmax, input bit seq);
    for (int i = 0; i < n; i++) begin
      logic [ASZ-1:0] s, d;
      logic [DSZ-1:0] t;
      s = ASZ'($urandom);
      d = ASZ'($urandom);
      t = seq ? DSZ'(i) : DSZ'($urandom);
      applyStimulus(g, k, s, d, t, calcRedun(s, d, t));
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
    end
  endtask

  // Output responder: checks each forwarded message against the head of the model queue.
  task automatic respond(input int g, input int n, input int dly);
    int m;
    m = (g == 0) ? 256 : 4;
    for (int i = 0; i < n; i++) begin
      acc_t e;
      for (int w = 0; w < TMO && o_req[g] !== 1'b1; w++) @(negedge clk);
      if (o_req[g] !== 1'b1) begin
        checkOutput("oreq_timeout", 64'(o_req[g]), 64'd1);
        return;
      end
      if (acc_q[g].size() == 0) begin
        checkOutput("unexpected_oreq", 64'(acc_q[g].size()), 64'd1);
        e = '0;
      end else begin
        e = acc_q[g].pop_front();
      end
      checkOutput("o_msg", 64'({o_src[g], o_dst[g], o_dat[g], o_red[g]}), 64'(e[MW-1:0]));
      checkOutput("grant", 64'(grant[g]), 64'(e[MW]));
      order_q[g].push_back(int'(e[MW]));
      repeat ((dly < 0) ? $urandom_range(1, 4) : dly) @(negedge clk);
      o_ack[g] = 1'b1;
      for (int w = 0; w < TMO && o_req[g] !== 1'b0; w++) @(negedge clk);
      if (o_req[g] !== 1'b0) checkOutput("oreq_fall_timeout", 64'(o_req[g]), 64'd0);
      cnt_model[g][e[MW]]++;
      checkOutput("cnt0", 64'(cnt0[g]), 64'(cnt_model[g][0] % m));
      checkOutput("cnt1", 64'(cnt1[g]), 64'(cnt_model[g][1] % m));
      o_ack[g] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r0, n00, n01, n10, n11;
    logic [RSZ-1:0] badred;
    for (int g = 0; g < 2; g++) begin
      oreq_rises[g] = 0;
      for (int k = 0; k < 2; k++) begin
        i_src[g][k] = '0; i_dst[g][k] = '0; i_dat[g][k] = '0; i_red[g][k] = '0;
      end
    end
    applyReset();
    for (int g = 0; g < 2; g++) begin
      checkOutput("rst_oreq", 64'(o_req[g]), 64'd0);
      checkOutput("rst_ack0", 64'(i_ack[g][0]), 64'd0);
      checkOutput("rst_ack1", 64'(i_ack[g][1]), 64'd0);
      checkOutput("rst_grant", 64'(grant[g]), 64'd1);
      checkOutput("rst_cnt0", 64'(cnt0[g]), 64'd0);
      checkOutput("rst_cnt1", 64'(cnt1[g]), 64'd0);
      checkOutput("rst_err", 64'(err[g]), 64'd0);
      checkOutput("rst_omsg", 64'({o_src[g], o_dst[g], o_dat[g], o_red[g]}), 64'd0);
    end

    $display("[TB] single message");
    r0 = oreq_rises[0];
    fork
      applyStimulus(0, 0, 8'd9, 8'd1, 16'd5, calcRedun(8'd9, 8'd1, 16'd5));
      respond(0, 1, 3);
    join
    repeat (4) @(negedge clk);
    checkOutput("single_pulses", 64'(oreq_rises[0] - r0), 64'd1);
    checkOutput("single_grant", 64'(grant[0]), 64'd0);
    checkOutput("single_err", 64'(err[0]), 64'd0);
    checkOutput("single_hold", 64'({o_src[0], o_dst[0], o_dat[0]}), 64'({8'd9, 8'd1, 16'd5}));

    $display("[TB] round-robin saturation");
    applyReset();
    fork
      streamMsgs(0, 0, 4, 0, 1'b1);
      streamMsgs(0, 1, 4, 0, 1'b1);
      respond(0, 8, -1);
    join
    checkOutput("rr_len", 64'(order_q[0].size()), 64'd8);
    for (int i = 0; i < order_q[0].size(); i++) checkOutput("rr_order", 64'(order_q[0][i]), 64'(i % 2));

    $display("[TB] fixed priority and counter wrap");
    applyReset();
    fork
      streamMsgs(1, 0, 4, 0, 1'b1);
      streamMsgs(1, 1, 1, 0, 1'b1);
      respond(1, 5, -1);
    join
    checkOutput("fp_len", 64'(order_q[1].size()), 64'd5);
    for (int i = 0; i < order_q[1].size(); i++) checkOutput("fp_order", 64'(order_q[1][i]), 64'(i / 4));
    applyReset();
    fork
      streamMsgs(1, 1, 5, 2, 1'b0);
      respond(1, 5, -1);
    join
    checkOutput("wrap_cnt1", 64'(cnt1[1]), 64'd1);

    $display("[TB] reset during output request");
    applyReset();
    fork
      streamMsgs(0, 0, 1, 0, 1'b0);
      respond(0, 1, -1);
    join
    streamMsgs(0, 0, 1, 0, 1'b0);
    for (int w = 0; w < 20 && o_req[0] !== 1'b1; w++) @(negedge clk);
    checkOutput("midop_oreq", 64'(o_req[0]), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midop_oreq_rst", 64'(o_req[0]), 64'd0);
    checkOutput("midop_acks", 64'({i_ack[0][0], i_ack[0][1]}), 64'd0);
    checkOutput("midop_cnt0", 64'(cnt0[0]), 64'd0);
    checkOutput("midop_omsg", 64'({o_src[0], o_dst[0], o_dat[0], o_red[0]}), 64'd0);
    acc_q[0].delete();
    cnt_model[0][0] = 0;
    cnt_model[0][1] = 0;
    fork
      streamMsgs(0, 1, 1, 0, 1'b0);
      respond(0, 1, -1);
    join

    $display("[TB] corrupted redundancy");
    applyReset();
    r0 = oreq_rises[0];
    badred = calcRedun(8'd3, 8'd4, 16'h0bad) ^ 4'd1;
    fork
      applyStimulus(0, 0, 8'd3, 8'd4, 16'h0bad, badred);
      respond(0, CHECK_EN ? 0 : 1, -1);
    join
    repeat (5) @(negedge clk);
    checkOutput("redun_pulses", 64'(oreq_rises[0] - r0), CHECK_EN ? 64'd0 : 64'd1);
    checkOutput("redun_err", 64'(err[0]), 64'(CHECK_EN));
    checkOutput("redun_cnt0", 64'(cnt0[0]), CHECK_EN ? 64'd0 : 64'd1);
    fork
      streamMsgs(0, 1, 1, 0, 1'b0);
      respond(0, 1, -1);
    join
    checkOutput("redun_cnt1", 64'(cnt1[0]), 64'd1);
    checkOutput("redun_err_sticky", 64'(err[0]), 64'(CHECK_EN));

    $display("[TB] protocol violation");
    applyReset();
    o_ack[1] = 1'b1;
    @(negedge clk);
    o_ack[1] = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("proto_err", 64'(err[1]), 64'd1);
    applyReset();
    checkOutput("proto_err_clr", 64'(err[1]), 64'd0);

    $display("[TB] randomized traffic");
    n00 = $urandom_range(3, 6);
    n01 = $urandom_range(3, 6);
    n10 = $urandom_range(3, 6);
    n11 = $urandom_range(3, 6);
    fork
      streamMsgs(0, 0, n00, 3, 1'b0);
      streamMsgs(0, 1, n01, 3, 1'b0);
      streamMsgs(1, 0, n10, 3, 1'b0);
      streamMsgs(1, 1, n11, 3, 1'b0);
      respond(0, n00 + n01, -1);
      respond(1, n10 + n11, -1);
    join
    checkOutput("rand_cnt0_i0", 64'(cnt0[0]), 64'(n00));
    checkOutput("rand_cnt1_i0", 64'(cnt1[0]), 64'(n01));
    checkOutput("rand_cnt0_i1", 64'(cnt0[1]), 64'(n10 % 4));
    checkOutput("rand_cnt1_i1", 64'(cnt1[1]), 64'(n11 % 4));
    checkOutput("rand_err", 64'({err[0], err[1]}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
